fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request this cycle.
REQ-006 SHALL have port imem_addr  output  32  read address, valid while imem_req=1.
REQ-007 SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after an accepted imem_req.
REQ-008 SHALL have port redirect  input  1  control-flow change (taken branch, j, jal, jr) from decode/execute.
REQ-009 SHALL have port redirect_pc  input  32  new fetch target, sampled when redirect=1.
REQ-010 SHALL have port instr  output  32  head instruction word (op = instr[31:26], funct = instr[5:0]) to the decoder.
REQ-011 SHALL have port instr_pc  output  32  address of head instruction.
REQ-012 SHALL have port pcplus4  output  32  instr_pc + 4, modulo 2^32.
REQ-013 SHALL have port instr_valid  output  1  queue head valid.
REQ-014 SHALL have port instr_ready  input  1  decoder accepts head this cycle (deasserted on stall).
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL keep fetch PC fpc; imem_addr = {fpc[31:2],2'b00}.
REQ-017 SHALL assert imem_req when reset deasserted, redirect=0, and count + inflight < DEPTH (inflight = 1 if a request was issued last cycle and not squashed).
REQ-018 SHALL advance fpc by 4 on each issued request; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 SHALL enqueue imem_rdata with its fetch address one cycle after issue unless squashed; enqueue never occurs when full (guaranteed by REQ-017).
REQ-020 SHALL dequeue head when instr_valid & instr_ready & ~redirect.
REQ-021 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and preserve order.
REQ-022 SHALL drive instr_valid = (count != 0); instr/instr_pc/pcplus4 combinational from head, 0 when empty.
REQ-023 SHALL on redirect=1: load fpc <= {redirect_pc[31:2],2'b00}, flush all entries (count <= 0), squash any in-flight response, ignore instr_ready that cycle; redirect has priority over every other event.
REQ-024 SHALL give redirect latency: redirect in cycle N -> imem_req with redirect target in N+1 -> data enqueued end of N+2 -> instr_valid=1 in N+3; no bypass path.
REQ-025 SHALL, on back-to-back redirects, honour only the latest redirect_pc.
REQ-026 SHALL sustain one instruction per cycle when instr_ready held high and no redirect.

Reset
REQ-027 SHALL on reset=0 immediately clear queue, count=0, instr_valid=0, imem_req=0, inflight=0, fpc=RESET_PC.
REQ-028 SHALL discard any response arriving in the first cycle after reset release.
REQ-029 SHALL issue imem_req with imem_addr=RESET_PC in the first cycle after reset release.

Verification
REQ-030 Reset release, instr_ready=1, imem returns addr as data -> imem_addr 0,4,8,...; instr_valid first high cycle 2; instr=instr_pc each cycle, pcplus4=instr_pc+4.
REQ-031 instr_ready=0 from reset -> exactly DEPTH(4) requests (0..0xC), count=4, imem_req=0 thereafter; raise ready -> heads 0,4,8,C in order, fetching resumes at 0x10.
REQ-032 Redirect to 0x0000_0101 in cycle N with 3 entries queued and one in flight -> count=0 at N+1, imem_addr=0x100 at N+1, stale data never appears, instr_pc=0x100 at N+3.
REQ-033 Redirect in cycles N and N+1 (targets 0x40, 0x80) -> no fetch from 0x40 reaches output; first instr_pc=0x80 at N+4.
REQ-034 fpc=0xFFFF_FFF8 via redirect -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pcplus4 for 0xFFFF_FFFC = 0x0.
REQ-035 Assert reset=0 mid-stream with full queue and request in flight -> outputs clear asynchronously; after release first instr_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch unit with a small in-order queue between instruction
// memory and the decoder. A fetch PC (fpc) is walked forward by 4 for every
// issued read. The word returned one cycle later is enqueued together with
// its fetch address. A redirect flushes the queue, squashes the read in
// flight and restarts fetching at the new target on the following cycle.
//
// Parameters
//   DEPTH    : number of queue entries (power of two, 2..16)
//   RESET_PC : first fetch address after reset
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous active-low reset
//   imem_req     out  instruction-memory read request this cycle
//   imem_addr    out  word-aligned read address (valid while imem_req=1)
//   imem_rdata   in   read data, one cycle after an issued request
//   redirect     in   control-flow change from decode/execute
//   redirect_pc  in   new fetch target, sampled while redirect=1
//   instr        out  head instruction word (0 when empty)
//   instr_pc     out  address of the head instruction (0 when empty)
//   pcplus4      out  instr_pc + 4 modulo 2^32 (0 when empty)
//   instr_valid  out  queue head valid
//   instr_ready  in   decoder accepts the head this cycle
//   count        out  number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [31:0]               imem_addr,
    input  logic [31:0]               imem_rdata,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    output logic [31:0]               instr,
    output logic [31:0]               instr_pc,
    output logic [31:0]               pcplus4,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Architectural state
    logic [31:0]   fpc_q,         fpc_d;
    logic          inflight_q,    inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] head_q,        head_d;
    logic [PW-1:0] tail_q,        tail_d;
    logic [CW-1:0] count_q,       count_d;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_pc_d    [DEPTH];

    // Combinational helpers
    logic [31:0]   addr_s;
    logic [CW:0]   occ_s;
    logic          issue_s;
    logic          enq_s;
    logic          deq_s;
    logic          empty_s;

    // The low address bits are forced to zero so an unaligned RESET_PC or
    // redirect target still produces a word-aligned fetch.
    assign addr_s    = fpc_q & 32'hFFFF_FFFC;
    assign imem_addr = addr_s;
    assign imem_req  = issue_s;
    assign count     = count_q;
    assign empty_s   = (count_q == CW'(0));
    assign instr_valid = ~empty_s;

    // Issue decision: entries already queued plus the word still in flight
    // must leave room, so an enqueue can never find the queue full.
    always_comb begin
        occ_s   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue_s = 1'b0;
        if (reset && !redirect && (occ_s < DEPTH_W)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Enqueue/dequeue qualifiers; a redirect overrides both.
    always_comb begin
        enq_s = inflight_q & ~redirect;
        deq_s = ~empty_s & instr_ready & ~redirect;
    end

    // Next-state logic for fetch PC, in-flight tracking and the queue.
    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        mem_instr_d   = mem_instr_q;
        mem_pc_d      = mem_pc_q;
        if (redirect) begin
            // Flush everything; the response of a request issued last cycle
            // is dropped because inflight is cleared without enqueueing.
            fpc_d      = redirect_pc & 32'hFFFF_FFFC;
            inflight_d = 1'b0;
            head_d     = PW'(0);
            tail_d     = PW'(0);
            count_d    = CW'(0);
        end else begin
            if (issue_s) begin
                fpc_d         = addr_s + 32'd4;
                inflight_pc_d = addr_s;
            end else begin
                fpc_d         = fpc_q;
                inflight_pc_d = inflight_pc_q;
            end
            inflight_d = issue_s;

            if (enq_s) begin
                mem_instr_d[tail_q] = imem_rdata;
                mem_pc_d[tail_q]    = inflight_pc_q;
                tail_d              = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end

            if (deq_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end

            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Head presentation to the decoder; all zero while the queue is empty.
    always_comb begin
        if (!empty_s) begin
            instr    = mem_instr_q[head_q];
            instr_pc = mem_pc_q[head_q];
            pcplus4  = mem_pc_q[head_q] + 32'd4;
        end else begin
            instr    = 32'd0;
            instr_pc = 32'd0;
            pcplus4  = 32'd0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            head_q        <= PW'(0);
            tail_q        <= PW'(0);
            count_q       <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= 32'd0;
                mem_pc_q[i]    <= 32'd0;
            end
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= mem_instr_d[i];
                mem_pc_q[i]    <= mem_pc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue (DEPTH=4, RESET_PC=0). Instruction memory
// returns the requested address as data one cycle after a request, and a
// recognisable junk word otherwise. Inputs change on the falling edge and
// outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pcplus4;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  count;

    int tests;
    int fails;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pcplus4     (pcplus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: data equals address of the request seen at the edge.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? imem_addr : 32'hBAD0_BAD0;
    end

    typedef struct packed {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic rdy, input logic req, input logic [31:0] addr,
                                input logic valid, input logic [31:0] pc, input logic [2:0] cnt);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.cnt = cnt;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Compare every output against the expected head/request state.
    // Memory returns address as data, so instr must equal the head address.
    task automatic check(input string lbl, input logic req, input logic [31:0] addr,
                         input logic valid, input logic [31:0] pc, input logic [2:0] cnt);
        logic [31:0] e_instr;
        logic [31:0] e_p4;
        e_instr = valid ? pc : 32'd0;
        e_p4    = valid ? (pc + 32'd4) : 32'd0;
        cmp({lbl, ".imem_req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) cmp({lbl, ".imem_addr"}, imem_addr, addr);
        cmp({lbl, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, valid});
        cmp({lbl, ".instr_pc"}, instr_pc, pc);
        cmp({lbl, ".instr"}, instr, e_instr);
        cmp({lbl, ".pcplus4"}, pcplus4, e_p4);
        cmp({lbl, ".count"}, {29'd0, count}, {29'd0, cnt});
    endtask

    // Advance to the next cycle and apply inputs away from the rising edge.
    task automatic cyc(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset       = rst;
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = rdy;
        #1;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        #1 reset = 1'b0;

        // Streaming with ready high: one instruction per cycle from cycle 2.
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 3'd0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 3'd1));
        // Decoder stalled from reset: exactly four fetches, then drain in order.
        vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 3'd0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 3'd0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 3'd1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00, 3'd2));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 3'd3));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 3'd4));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h00, 3'd4));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h00, 3'd4));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04, 3'd3));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 3'd2));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 3'd2));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd2));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                  vecs[i].valid, vecs[i].pc, vecs[i].cnt);
        end

        // Redirect with three queued and one in flight.
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0000_0101, 1'b1);
        check("redir_n",  1'b0, 32'h0,   1'b1, 32'h000, 3'd3);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_n1", 1'b1, 32'h100, 1'b0, 32'h000, 3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_n2", 1'b1, 32'h104, 1'b0, 32'h000, 3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_n3", 1'b1, 32'h108, 1'b1, 32'h100, 3'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("redir_n4", 1'b1, 32'h10C, 1'b1, 32'h104, 3'd1);

        // Back-to-back redirects: only the second target is fetched.
        cyc(1'b1, 1'b1, 32'h0000_0040, 1'b1);
        check("b2b_n",  1'b0, 32'h0,  1'b1, 32'h108, 3'd1);
        cyc(1'b1, 1'b1, 32'h0000_0080, 1'b1);
        check("b2b_n1", 1'b0, 32'h0,  1'b0, 32'h0,   3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("b2b_n2", 1'b1, 32'h80, 1'b0, 32'h0,   3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("b2b_n3", 1'b1, 32'h84, 1'b0, 32'h0,   3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("b2b_n4", 1'b1, 32'h88, 1'b1, 32'h80,  3'd1);

        // Address wrap at the top of the 32-bit space.
        cyc(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        check("wrap_n",  1'b0, 32'h0,         1'b1, 32'h84,        3'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_n1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,         3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_n2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_n3", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8, 3'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_n4", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 3'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_n5", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 3'd1);

        // Asynchronous reset mid-stream with entries queued and one in flight.
        cyc(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        check("ar_n",  1'b0, 32'h0,   1'b1, 32'h04,  3'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        check("ar_n1", 1'b1, 32'h200, 1'b0, 32'h0,   3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        check("ar_n2", 1'b1, 32'h204, 1'b0, 32'h0,   3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        check("ar_n3", 1'b1, 32'h208, 1'b1, 32'h200, 3'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        check("ar_n4", 1'b1, 32'h20C, 1'b1, 32'h200, 3'd2);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        check("ar_n5", 1'b0, 32'h0,   1'b1, 32'h200, 3'd3);
        #2 reset = 1'b0;
        #1;
        check("ar_async", 1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("ar_hold",  1'b0, 32'h0, 1'b0, 32'h0, 3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("ar_rel0",  1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("ar_rel1",  1'b1, 32'h4, 1'b0, 32'h0, 3'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("ar_rel2",  1'b1, 32'h8, 1'b1, 32'h0, 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
